// File: rtl/i2c_target_phy_if.sv
// global_if: system-wide control signals shared by the I2C target blocks
interface global_if;
    logic reset;
    modport master (output reset);
    modport slave (input reset);
endinterface

// File: rtl/i2c_target_phy.sv
// i2c_target_phy: I2C target bit layer; START/STOP detect, byte deserialiser, write-only ACK generation
module i2c_target_phy #(
    parameter logic [6:0] DEVICE_ADDR = 7'h40,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    global_if.slave       g_if,
    input  logic          scl_in,
    input  logic          sda_in,
    output logic          sda_oe,
    output logic          start,
    output logic          stop,
    output logic          rx_valid,
    output logic [7:0]    rx_data
);
    typedef enum logic [2:0] {IDLE, ADDR, ACK_A, DATA, ACK_D, IGNORE} state_t;

    state_t state, state_n;
    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic scl_q, sda_q;
    logic [7:0] shift, shift_n, rx_data_n;
    logic [3:0] bit_cnt, bit_cnt_n;
    logic sda_oe_n, start_n, stop_n, rx_valid_n;

    wire scl_s = scl_sync[SYNC_STAGES-1];
    wire sda_s = sda_sync[SYNC_STAGES-1];
    // SCL must be stable high across both samples, so simultaneous SCL/SDA toggles never decode as START/STOP
    wire start_ev = scl_q & scl_s & sda_q & ~sda_s;
    wire stop_ev = scl_q & scl_s & ~sda_q & sda_s;
    wire scl_rise = ~scl_q & scl_s;
    wire scl_fall = scl_q & ~scl_s;
    wire [7:0] byte_n = {shift[6:0], sda_s};
    wire addr_match = (shift[7:1] == DEVICE_ADDR) && !shift[0];

    always_ff @(posedge clk) begin
        if (g_if.reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_q <= 1'b1;
            sda_q <= 1'b1;
            state <= IDLE;
            shift <= 8'h00;
            bit_cnt <= 4'd0;
            sda_oe <= 1'b0;
            start <= 1'b0;
            stop <= 1'b0;
            rx_valid <= 1'b0;
            rx_data <= 8'h00;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_q <= scl_s;
            sda_q <= sda_s;
            state <= state_n;
            shift <= shift_n;
            bit_cnt <= bit_cnt_n;
            sda_oe <= sda_oe_n;
            start <= start_n;
            stop <= stop_n;
            rx_valid <= rx_valid_n;
            rx_data <= rx_data_n;
        end
    end

    always_comb begin
        state_n = state;
        shift_n = shift;
        bit_cnt_n = bit_cnt;
        sda_oe_n = sda_oe;
        rx_data_n = rx_data;
        start_n = 1'b0;
        stop_n = 1'b0;
        rx_valid_n = 1'b0;
        if (start_ev) begin
            state_n = ADDR;
            bit_cnt_n = 4'd0;
            sda_oe_n = 1'b0;
            start_n = 1'b1;
        end else if (stop_ev) begin
            state_n = IDLE;
            sda_oe_n = 1'b0;
            stop_n = 1'b1;
        end else begin
            case (state)
                ADDR, DATA: begin
                    if (scl_rise && bit_cnt < 4'd8) begin
                        shift_n = byte_n;
                        bit_cnt_n = bit_cnt + 4'd1;
                        rx_valid_n = (bit_cnt == 4'd7);
                        rx_data_n = (bit_cnt == 4'd7) ? byte_n : rx_data;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        // ACK is driven from the start of the 9th SCL low phase
                        state_n = (state == ADDR) ? ACK_A : ACK_D;
                        sda_oe_n = (state == ADDR) ? addr_match : 1'b1;
                    end
                end
                ACK_A, ACK_D: begin
                    if (scl_fall) begin
                        state_n = (state == ACK_D || sda_oe) ? DATA : IGNORE;
                        sda_oe_n = 1'b0;
                        bit_cnt_n = 4'd0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_target_phy.sv
// tb_i2c_target_phy: randomized I2C write traffic against a byte-level bus model with a decoupled scoreboard
module tb_i2c_target_phy;
    localparam int Q = 60;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    global_if g_if();
    logic scl = 1'b1, sda_m = 1'b1;
    logic sda_in, sda_oe, start, stop, rx_valid;
    logic [7:0] rx_data;
    assign sda_in = sda_m & ~sda_oe;

    i2c_target_phy #(.DEVICE_ADDR(7'h40), .SYNC_STAGES(2)) dut (
        .clk(clk), .g_if(g_if), .scl_in(scl), .sda_in(sda_in),
        .sda_oe(sda_oe), .start(start), .stop(stop),
        .rx_valid(rx_valid), .rx_data(rx_data)
    );

    int n_chk = 0, n_fail = 0;
    int exp_start = 0, exp_stop = 0, obs_start = 0, obs_stop = 0;
    logic [7:0] exp_q[$];
    // bus model: 0 idle, 1 expecting address byte, 2 addressed (data), 3 ignored
    int mode = 0;
    logic p_start = 0, p_stop = 0, p_valid = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (start) obs_start++;
        if (stop) obs_stop++;
        if (rx_valid) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL rx_valid_unexpected: got data %0h, expected no strobe at %0t", rx_data, $time);
            end else chk("rx_data", rx_data, exp_q.pop_front());
        end
        if ((start && p_start) || (stop && p_stop) || (rx_valid && p_valid))
            chk("pulse_width", {29'd0, start, stop, rx_valid}, 32'd0);
        p_start = start;
        p_stop = stop;
        p_valid = rx_valid;
    end

    task automatic put_bit(input logic b);
        sda_m = b;
        #Q scl = 1'b1;
        #Q chk("oe_in_data_bit", sda_oe, 0);
        #Q scl = 1'b0;
        #Q;
    endtask

    task automatic ack_slot(input logic exp_ack);
        sda_m = 1'b1;
        #Q scl = 1'b1;
        #Q chk("ack", sda_oe, exp_ack);
        #Q scl = 1'b0;
        #Q;
    endtask

    task automatic do_start;
        exp_start++;
        mode = 1;
        sda_m = 1'b1;
        #Q scl = 1'b1;
        #Q sda_m = 1'b0;
        #Q scl = 1'b0;
        #Q;
    endtask

    task automatic do_stop;
        exp_stop++;
        mode = 0;
        sda_m = 1'b0;
        #Q scl = 1'b1;
        #Q sda_m = 1'b1;
        #(2*Q);
        chk("oe_after_stop", sda_oe, 0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic ack;
        ack = 1'b0;
        if (mode == 1) begin
            exp_q.push_back(b);
            ack = (b[7:1] == 7'h40) && !b[0];
            mode = ack ? 2 : 3;
        end else if (mode == 2) begin
            exp_q.push_back(b);
            ack = 1'b1;
        end
        for (int i = 7; i >= 0; i--) put_bit(b[i]);
        if (mode == 1 || mode == 2 || ack) chk("rx_data_hold", rx_data, b);
        ack_slot(ack);
    endtask

    initial begin
        logic [7:0] a;
        int n;
        g_if.reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_oe", sda_oe, 0);
        chk("rst_start", start, 0);
        chk("rst_stop", stop, 0);
        chk("rst_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 8'h00);
        @(negedge clk) g_if.reset = 1'b0;
        repeat (5) @(negedge clk);

        do_start; send_byte(8'h80); send_byte(8'h06); send_byte(8'h5A); do_stop;
        do_start; send_byte(8'h82); send_byte(8'h06); send_byte(8'h11); do_stop;
        send_byte(8'h80);
        do_start; send_byte(8'h81); send_byte(8'h06); send_byte(8'h22); do_stop;
        do_start; send_byte(8'h80); send_byte(8'h06);
        do_start; send_byte(8'h80); send_byte(8'h07); send_byte(8'h33); do_stop;
        do_start; send_byte(8'h80);
        for (int i = 0; i < 4; i++) put_bit(i[0]);
        do_stop;
        do_start; send_byte(8'h80); send_byte(8'h09); send_byte(8'hC3); do_stop;

        do_start;
        exp_q.push_back(8'h80);
        for (int i = 7; i >= 0; i--) put_bit(i == 7);
        sda_m = 1'b1;
        #Q chk("oe_before_reset", sda_oe, 1);
        @(negedge clk) g_if.reset = 1'b1;
        @(posedge clk) #1 chk("oe_after_reset", sda_oe, 0);
        chk("rx_data_after_reset", rx_data, 8'h00);
        scl = 1'b1;
        repeat (5) @(negedge clk);
        g_if.reset = 1'b0;
        mode = 0;
        repeat (5) @(negedge clk);

        for (int t = 0; t < 25; t++) begin
            do_start;
            case ($urandom_range(0, 3))
                0: a = 8'h80;
                1: a = 8'h81;
                2: a = 8'($urandom);
                default: a = 8'h80;
            endcase
            send_byte(a);
            n = $urandom_range(0, 3);
            for (int k = 0; k < n; k++) send_byte(8'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                do_start;
                send_byte(8'h80);
                send_byte(8'($urandom));
            end
            do_stop;
        end

        repeat (50) @(negedge clk);
        chk("rx_queue_drained", exp_q.size(), 0);
        chk("start_count", obs_start, exp_start);
        chk("stop_count", obs_stop, exp_stop);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
